// File: rtl/mvm_uart_bridge.sv
// rtl/mvm_uart_bridge.sv - framed, checksummed UART byte link to MVM accelerator kx/y streams
module mvm_uart_bridge #(
   parameter int         W_IN    = 576,
   parameter int         R       = 8,
   parameter int         W_Y     = 19,
   parameter int         W_Y_OUT = 32,
   parameter bit         SIGNED  = 1'b1,
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         TIMEOUT = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_byte_tvalid,
   output logic                 s_byte_tready,
   input  logic [7:0]           s_byte_tdata,
   output logic                 m_kx_tvalid,
   input  logic                 m_kx_tready,
   output logic [W_IN-1:0]      m_kx_tdata,
   input  logic                 s_y_tvalid,
   output logic                 s_y_tready,
   input  logic [R*W_Y-1:0]     s_y_tdata,
   output logic                 m_byte_tvalid,
   input  logic                 m_byte_tready,
   output logic [7:0]           m_byte_tdata,
   output logic                 frame_err,
   output logic [15:0]          err_count
);

   localparam int N_IN  = W_IN / 8;
   localparam int N_OUT = R * W_Y_OUT / 8;
   localparam int IXW   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int OXW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {RX_HUNT, RX_PAYLOAD, RX_CHECK, RX_ISSUE} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_CSUM} tx_state_t;

   rx_state_t            rx_state;
   logic [IXW-1:0]       rx_idx;
   logic [7:0]           rx_csum;
   logic [TW-1:0]        idle_cnt;
   logic [W_IN-1:0]      kx_data;
   logic                 rx_acc;
   logic                 timeout_hit;
   logic [15:0]          err_inc;

   tx_state_t            tx_state;
   logic [N_OUT*8-1:0]   tx_buf;
   logic [N_OUT*8-1:0]   y_ext;
   logic [OXW-1:0]       tx_idx;
   logic [7:0]           tx_csum;
   logic [7:0]           tx_byte;

   // Handshake qualifiers are forced low while reset is asserted.
   assign s_byte_tready = !rst && (rx_state != RX_ISSUE);
   assign m_kx_tvalid   = !rst && (rx_state == RX_ISSUE);
   assign m_kx_tdata    = kx_data;
   assign s_y_tready    = !rst && (tx_state == TX_IDLE);
   assign m_byte_tvalid = !rst && (tx_state != TX_IDLE);
   assign m_byte_tdata  = tx_byte;

   assign rx_acc      = s_byte_tvalid && s_byte_tready;
   assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == TW'(TIMEOUT));
   assign err_inc     = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

   // Extend every result lane to W_Y_OUT bits, replicating the lane MSB when signed.
   always_comb begin
      y_ext = '0;
      for (int r = 0; r < R; r++) begin
         for (int b = 0; b < W_Y_OUT; b++) begin
            if (b < W_Y || SIGNED)
               y_ext[r*W_Y_OUT + b] = s_y_tdata[r*W_Y + ((b < W_Y) ? b : W_Y - 1)];
         end
      end
   end

   // RX framing: hunt for sync, collect payload, verify XOR checksum, issue word.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state  <= RX_HUNT;
         rx_idx    <= '0;
         rx_csum   <= '0;
         idle_cnt  <= '0;
         kx_data   <= '0;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         frame_err <= 1'b0;
         case (rx_state)
            RX_HUNT: begin
               if (rx_acc && s_byte_tdata == SYNC) begin
                  rx_state <= RX_PAYLOAD;
                  rx_idx   <= '0;
                  rx_csum  <= '0;
                  idle_cnt <= '0;
               end
            end
            RX_PAYLOAD: begin
               if (rx_acc) begin
                  for (int k = 0; k < N_IN; k++) begin
                     if (rx_idx == IXW'(k))
                        kx_data[8*k +: 8] <= s_byte_tdata;
                  end
                  rx_csum  <= rx_csum ^ s_byte_tdata;
                  idle_cnt <= '0;
                  if (rx_idx == IXW'(N_IN - 1))
                     rx_state <= RX_CHECK;
                  else
                     rx_idx <= rx_idx + 1'b1;
               end else if (timeout_hit) begin
                  rx_state  <= RX_HUNT;
                  frame_err <= 1'b1;
                  err_count <= err_inc;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            RX_CHECK: begin
               if (rx_acc) begin
                  idle_cnt <= '0;
                  if (s_byte_tdata == rx_csum) begin
                     rx_state <= RX_ISSUE;
                  end else begin
                     rx_state  <= RX_HUNT;
                     frame_err <= 1'b1;
                     err_count <= err_inc;
                  end
               end else if (timeout_hit) begin
                  rx_state  <= RX_HUNT;
                  frame_err <= 1'b1;
                  err_count <= err_inc;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            RX_ISSUE: begin
               if (m_kx_tready)
                  rx_state <= RX_HUNT;
            end
            default: rx_state <= RX_HUNT;
         endcase
      end
   end

   // TX framing: latch extended lanes, then emit sync, data bytes and XOR checksum.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_buf   <= '0;
         tx_idx   <= '0;
         tx_csum  <= '0;
         tx_byte  <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (s_y_tvalid) begin
                  tx_buf   <= y_ext;
                  tx_byte  <= SYNC;
                  tx_state <= TX_SYNC;
               end
            end
            TX_SYNC: begin
               if (m_byte_tready) begin
                  tx_byte  <= tx_buf[7:0];
                  tx_buf   <= tx_buf >> 8;
                  tx_idx   <= '0;
                  tx_csum  <= '0;
                  tx_state <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (m_byte_tready) begin
                  tx_csum <= tx_csum ^ tx_byte;
                  if (tx_idx == OXW'(N_OUT - 1)) begin
                     tx_byte  <= tx_csum ^ tx_byte;
                     tx_state <= TX_CSUM;
                  end else begin
                     tx_byte <= tx_buf[7:0];
                     tx_buf  <= tx_buf >> 8;
                     tx_idx  <= tx_idx + 1'b1;
                  end
               end
            end
            TX_CSUM: begin
               if (m_byte_tready) begin
                  tx_byte  <= '0;
                  tx_state <= TX_IDLE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mvm_uart_bridge.sv
// tb/tb_mvm_uart_bridge.sv - directed self-checking bench for mvm_uart_bridge
module tb_mvm_uart_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_byte_tvalid;
   logic [7:0]  s_byte_tdata;
   logic        m_kx_tready;
   logic        s_y_tvalid;
   logic [23:0] s_y_tdata;
   logic        m_byte_tready;

   logic        s_byte_tready, m_kx_tvalid, s_y_tready, m_byte_tvalid, frame_err;
   logic [15:0] m_kx_tdata, err_count;
   logic [7:0]  m_byte_tdata;

   logic        s_byte_tready_u, m_kx_tvalid_u, s_y_tready_u, m_byte_tvalid_u, frame_err_u;
   logic [15:0] m_kx_tdata_u, err_count_u;
   logic [7:0]  m_byte_tdata_u;

   int          checks = 0;
   int          errors = 0;
   int          fe_cnt = 0;
   int          kx_hs  = 0;
   logic [15:0] last_kx = '0;
   logic [15:0] prev_kx = '0;

   logic [7:0]  exp_s [6];
   logic [7:0]  exp_u [6];

   always #5 clk = ~clk;

   mvm_uart_bridge #(.W_IN(16), .R(2), .W_Y(12), .W_Y_OUT(16), .SIGNED(1'b1),
                     .SYNC(8'hA5), .TIMEOUT(100)) dut (
      .clk(clk), .rst(rst),
      .s_byte_tvalid(s_byte_tvalid), .s_byte_tready(s_byte_tready), .s_byte_tdata(s_byte_tdata),
      .m_kx_tvalid(m_kx_tvalid), .m_kx_tready(m_kx_tready), .m_kx_tdata(m_kx_tdata),
      .s_y_tvalid(s_y_tvalid), .s_y_tready(s_y_tready), .s_y_tdata(s_y_tdata),
      .m_byte_tvalid(m_byte_tvalid), .m_byte_tready(m_byte_tready), .m_byte_tdata(m_byte_tdata),
      .frame_err(frame_err), .err_count(err_count)
   );

   mvm_uart_bridge #(.W_IN(16), .R(2), .W_Y(12), .W_Y_OUT(16), .SIGNED(1'b0),
                     .SYNC(8'hA5), .TIMEOUT(100)) dut_u (
      .clk(clk), .rst(rst),
      .s_byte_tvalid(s_byte_tvalid), .s_byte_tready(s_byte_tready_u), .s_byte_tdata(s_byte_tdata),
      .m_kx_tvalid(m_kx_tvalid_u), .m_kx_tready(m_kx_tready), .m_kx_tdata(m_kx_tdata_u),
      .s_y_tvalid(s_y_tvalid), .s_y_tready(s_y_tready_u), .s_y_tdata(s_y_tdata),
      .m_byte_tvalid(m_byte_tvalid_u), .m_byte_tready(m_byte_tready), .m_byte_tdata(m_byte_tdata_u),
      .frame_err(frame_err_u), .err_count(err_count_u)
   );

   // Count frame_err pulses and kx handshakes, remembering the last two words.
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (m_kx_tvalid === 1'b1 && m_kx_tready === 1'b1) begin
         kx_hs++;
         prev_kx = last_kx;
         last_kx = m_kx_tdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic got;
      int   n;
      got = 1'b0;
      n = 0;
      s_byte_tvalid = 1'b1;
      s_byte_tdata  = b;
      while (!got && n < 300) begin
         @(negedge clk);
         got = s_byte_tready;
         @(posedge clk);
         n++;
      end
      #1;
      s_byte_tvalid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL send_byte %h not accepted got 0 exp 1", b);
      end
   endtask

   task automatic y_handshake(input logic [23:0] d);
      logic got;
      int   n;
      got = 1'b0;
      n = 0;
      s_y_tvalid = 1'b1;
      s_y_tdata  = d;
      while (!got && n < 300) begin
         @(negedge clk);
         got = s_y_tready;
         @(posedge clk);
         n++;
      end
      #1;
      s_y_tvalid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL y_handshake not accepted got 0 exp 1");
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      s_byte_tvalid = 1'b0; s_byte_tdata = '0; m_kx_tready = 1'b0;
      s_y_tvalid = 1'b0; s_y_tdata = '0; m_byte_tready = 1'b0;
      tick(3);
      @(negedge clk);
      checks++;
      if ({s_byte_tready, s_y_tready, m_kx_tvalid, m_byte_tvalid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_handshakes got %b exp 0000",
                  {s_byte_tready, s_y_tready, m_kx_tvalid, m_byte_tvalid});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_byte_tready, s_y_tready, s_byte_tready_u, s_y_tready_u} !== 4'b1111) begin
         errors++;
         $display("FAIL release_readies got %b exp 1111",
                  {s_byte_tready, s_y_tready, s_byte_tready_u, s_y_tready_u});
      end
      checks++;
      if ({m_kx_tdata, m_byte_tdata, frame_err, err_count} !== 41'd0) begin
         errors++;
         $display("FAIL reset_values kx %h byte %h fe %b cnt %h exp all 0",
                  m_kx_tdata, m_byte_tdata, frame_err, err_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_good_frame;
      int hs0;
      hs0 = kx_hs;
      m_kx_tready = 1'b0;
      send_byte(8'hA5); send_byte(8'h34); send_byte(8'h12); send_byte(8'h26);
      @(negedge clk);
      checks++;
      if (m_kx_tvalid !== 1'b1 || m_kx_tdata !== 16'h1234) begin
         errors++;
         $display("FAIL good_issue valid %b data %h exp 1 1234", m_kx_tvalid, m_kx_tdata);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (m_kx_tvalid !== 1'b1 || m_kx_tdata !== 16'h1234 || s_byte_tready !== 1'b0) begin
            errors++;
            $display("FAIL good_hold%0d valid %b data %h rdy %b exp 1 1234 0",
                     i, m_kx_tvalid, m_kx_tdata, s_byte_tready);
         end
      end
      @(posedge clk); #1;
      m_kx_tready = 1'b1;
      tick(1);
      @(negedge clk);
      checks++;
      if (m_kx_tvalid !== 1'b0 || s_byte_tready !== 1'b1) begin
         errors++;
         $display("FAIL good_release valid %b rdy %b exp 0 1", m_kx_tvalid, s_byte_tready);
      end
      checks++;
      if (kx_hs !== hs0 + 1 || last_kx !== 16'h1234) begin
         errors++;
         $display("FAIL good_handshake count %0d word %h exp %0d 1234", kx_hs, last_kx, hs0 + 1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_bad_checksum;
      int hs0, fe0;
      hs0 = kx_hs; fe0 = fe_cnt;
      m_kx_tready = 1'b1;
      send_byte(8'hA5); send_byte(8'h34); send_byte(8'h12); send_byte(8'h00);
      @(negedge clk);
      checks++;
      if (frame_err !== 1'b1 || err_count !== 16'd1 || m_kx_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL bad_csum fe %b cnt %h valid %b exp 1 0001 0", frame_err, err_count, m_kx_tvalid);
      end
      tick(3);
      checks++;
      if (fe_cnt !== fe0 + 1 || kx_hs !== hs0) begin
         errors++;
         $display("FAIL bad_csum_pulses fe %0d hs %0d exp %0d %0d", fe_cnt, kx_hs, fe0 + 1, hs0);
      end
      send_byte(8'hA5); send_byte(8'h34); send_byte(8'h12); send_byte(8'h26);
      tick(3);
      checks++;
      if (kx_hs !== hs0 + 1 || last_kx !== 16'h1234) begin
         errors++;
         $display("FAIL bad_then_good hs %0d word %h exp %0d 1234", kx_hs, last_kx, hs0 + 1);
      end
   endtask

   task automatic test_hunt_sync;
      logic [7:0] v [6];
      int hs0, fe0;
      v = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h12, 8'hB7};
      hs0 = kx_hs; fe0 = fe_cnt;
      for (int i = 0; i < 6; i++) send_byte(v[i]);
      tick(3);
      checks++;
      if (kx_hs !== hs0 + 1 || last_kx !== 16'h12A5 || fe_cnt !== fe0) begin
         errors++;
         $display("FAIL hunt_sync hs %0d word %h fe %0d exp %0d 12a5 %0d",
                  kx_hs, last_kx, fe_cnt, hs0 + 1, fe0);
      end
   endtask

   task automatic test_timeout;
      int hs0, fe0;
      hs0 = kx_hs; fe0 = fe_cnt;
      send_byte(8'hA5); send_byte(8'h34);
      tick(101);
      @(negedge clk);
      checks++;
      if (frame_err !== 1'b1 || err_count !== 16'd2) begin
         errors++;
         $display("FAIL timeout_abort fe %b cnt %h exp 1 0002", frame_err, err_count);
      end
      @(posedge clk); #1;
      send_byte(8'h12); send_byte(8'h26);
      tick(3);
      checks++;
      if (kx_hs !== hs0 || fe_cnt !== fe0 + 1 || err_count !== 16'd2) begin
         errors++;
         $display("FAIL timeout_drop hs %0d fe %0d cnt %h exp %0d %0d 0002",
                  kx_hs, fe_cnt, err_count, hs0, fe0 + 1);
      end
      send_byte(8'hA5); send_byte(8'h34);
      tick(100);
      send_byte(8'h12); send_byte(8'h26);
      tick(3);
      checks++;
      if (kx_hs !== hs0 + 1 || last_kx !== 16'h1234 || fe_cnt !== fe0 + 1) begin
         errors++;
         $display("FAIL timeout_edge_kept hs %0d word %h fe %0d exp %0d 1234 %0d",
                  kx_hs, last_kx, fe_cnt, hs0 + 1, fe0 + 1);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] v [8];
      int hs0;
      v = '{8'hA5, 8'h34, 8'h12, 8'h26, 8'hA5, 8'hCD, 8'hAB, 8'h66};
      hs0 = kx_hs;
      m_kx_tready = 1'b1;
      for (int i = 0; i < 8; i++) send_byte(v[i]);
      tick(3);
      checks++;
      if (kx_hs !== hs0 + 2 || prev_kx !== 16'h1234 || last_kx !== 16'hABCD) begin
         errors++;
         $display("FAIL back_to_back hs %0d words %h %h exp %0d 1234 abcd",
                  kx_hs, prev_kx, last_kx, hs0 + 2);
      end
   endtask

   task automatic test_tx;
      m_byte_tready = 1'b1;
      y_handshake(24'h005FFE);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (m_byte_tvalid !== 1'b1 || m_byte_tdata !== exp_s[i] || m_byte_tdata_u !== exp_u[i]) begin
            errors++;
            $display("FAIL tx_byte%0d valid %b s %h u %h exp 1 %h %h",
                     i, m_byte_tvalid, m_byte_tdata, m_byte_tdata_u, exp_s[i], exp_u[i]);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (m_byte_tvalid !== 1'b0 || s_y_tready !== 1'b1) begin
         errors++;
         $display("FAIL tx_end valid %b rdy %b exp 0 1", m_byte_tvalid, s_y_tready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_tx_stall;
      int idx, cyc;
      idx = 0; cyc = 0;
      m_byte_tready = 1'b0;
      y_handshake(24'h005FFE);
      while (idx < 6 && cyc < 300) begin
         @(negedge clk);
         checks++;
         if (m_byte_tvalid !== 1'b1 || m_byte_tdata !== exp_s[idx] || m_byte_tdata_u !== exp_u[idx]) begin
            errors++;
            $display("FAIL tx_stall byte%0d cyc%0d valid %b s %h u %h exp 1 %h %h",
                     idx, cyc, m_byte_tvalid, m_byte_tdata, m_byte_tdata_u, exp_s[idx], exp_u[idx]);
         end
         if (m_byte_tready) idx++;
         @(posedge clk); #1;
         m_byte_tready = 1'($urandom_range(0, 1));
         cyc++;
      end
      checks++;
      if (idx != 6) begin
         errors++;
         $display("FAIL tx_stall_done bytes %0d exp 6", idx);
      end
      m_byte_tready = 1'b1;
      @(negedge clk);
      checks++;
      if (m_byte_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL tx_stall_end valid %b exp 0", m_byte_tvalid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int hs0;
      m_kx_tready = 1'b1;
      m_byte_tready = 1'b1;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      tick(2);
      checks++;
      if (err_count !== 16'd3) begin
         errors++;
         $display("FAIL mid_pre_count got %h exp 0003", err_count);
      end
      send_byte(8'hA5); send_byte(8'h34);
      y_handshake(24'h005FFE);
      tick(2);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({s_byte_tready, s_y_tready, m_kx_tvalid, m_byte_tvalid} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_rst_handshakes got %b exp 0000",
                  {s_byte_tready, s_y_tready, m_kx_tvalid, m_byte_tvalid});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (err_count !== 16'd0 || m_byte_tvalid !== 1'b0 || m_byte_tdata !== 8'h00 || s_byte_tready !== 1'b1) begin
         errors++;
         $display("FAIL mid_after_rst cnt %h bvalid %b bdata %h rdy %b exp 0000 0 00 1",
                  err_count, m_byte_tvalid, m_byte_tdata, s_byte_tready);
      end
      @(posedge clk); #1;
      m_kx_tready = 1'b0;
      send_byte(8'hA5); send_byte(8'h34); send_byte(8'h12); send_byte(8'h26);
      tick(1);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (m_kx_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL kx_withdraw valid %b exp 0", m_kx_tvalid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      m_kx_tready = 1'b1;
      hs0 = kx_hs;
      send_byte(8'hA5); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h66);
      tick(3);
      checks++;
      if (kx_hs !== hs0 + 1 || last_kx !== 16'hABCD || err_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_recover_rx hs %0d word %h cnt %h exp %0d abcd 0000",
                  kx_hs, last_kx, err_count, hs0 + 1);
      end
      test_tx();
   endtask

   initial begin
      exp_s = '{8'hA5, 8'hFE, 8'hFF, 8'h05, 8'h00, 8'h04};
      exp_u = '{8'hA5, 8'hFE, 8'h0F, 8'h05, 8'h00, 8'hF4};
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_hunt_sync();
      test_timeout();
      test_back_to_back();
      test_tx();
      test_tx_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mvm_uart_bridge.md
# mvm_uart_bridge

Framed, checksummed byte-protocol bridge between a UART byte link and a wide AXI-Stream matrix-vector accelerator. It is the parametrised successor of the fixed UART-to-MVM top. Receive framing (sync hunt, XOR checksum, inter-byte timeout) replaces blind deserialisation. Output lanes are sign- or zero-extended to a configurable width, checksummed on transmit, and errors are counted. It sits between a byte-wide UART RX/TX PHY and the accelerator's `kx`/`y` streams.

## Interface
- `W_IN`, 576: accelerator input bus width; multiple of 8; N_IN = W_IN/8 payload bytes.
- `R`, 8: output lanes.
- `W_Y`, 19: accelerator lane width.
- `W_Y_OUT`, 32: transmitted lane width; multiple of 8, ≥ W_Y; N_OUT = R*W_Y_OUT/8 bytes.
- `SIGNED`, 1: 1 sign-extends lanes, 0 zero-extends.
- `SYNC`, 8'hA5: frame start byte, both directions.
- `TIMEOUT`, 65535: max idle cycles between bytes inside an RX frame; 0 disables.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_byte_tvalid / s_byte_tready / s_byte_tdata`  in/out/in  1/1/8  bytes from UART RX.
- `m_kx_tvalid / m_kx_tready / m_kx_tdata`  out/in/out  1/1/W_IN  word to accelerator.
- `s_y_tvalid / s_y_tready / s_y_tdata`  in/out/in  1/1/R*W_Y  result from accelerator; lane r at [W_Y*(r+1)-1 : W_Y*r].
- `m_byte_tvalid / m_byte_tready / m_byte_tdata`  out/in/out  1/1/8  bytes to UART TX.
- `frame_err`  out  1  one-cycle pulse per discarded RX frame.
- `err_count`  out  16  discarded-frame count, saturating at 16'hFFFF.

## Operation
- RX FSM states: HUNT, PAYLOAD, CHECK, ISSUE.
  - HUNT: accepts and drops bytes until one equals SYNC, then goes to PAYLOAD with byte index 0 and checksum 0.
  - PAYLOAD: byte k loads `m_kx_tdata[8k+7:8k]` (little-endian) and is XORed into the checksum. After byte N_IN-1, go to CHECK.
  - CHECK: the accepted byte is compared with the running XOR. Match -> ISSUE. Mismatch -> pulse `frame_err`, increment `err_count`, go to HUNT.
  - ISSUE: `m_kx_tvalid`=1 with data held stable until `m_kx_tready`; on the handshake, go to HUNT.
- A SYNC value inside the payload or checksum is ordinary data; there is no escaping.
- `s_byte_tready` is 1 in HUNT/PAYLOAD/CHECK, 0 in ISSUE and while `rst` is high.
- Timeout:
  - In PAYLOAD/CHECK, an idle counter clears on every accepted byte and increments otherwise.
  - When it reaches TIMEOUT: abort to HUNT, pulse `frame_err`, increment `err_count`.
  - If a byte is accepted in the same cycle the timeout fires, the byte wins and there is no abort.
- TX FSM states: IDLE, SYNC, DATA, CSUM. It is independent of the RX FSM.
  - IDLE: `s_y_tready`=1. On handshake, register every lane extended to W_Y_OUT (per SIGNED), go to SYNC.
  - SYNC: emit SYNC.
  - DATA: emit N_OUT bytes, lane 0 first, each lane little-endian.
  - CSUM: emit the XOR of the N_OUT data bytes, then return to IDLE.
- Each state or byte advances only on an `m_byte` handshake. `m_byte_tdata` is stable while `tvalid`=1 and `tready`=0.
- Reset mid-operation: the partial RX frame is dropped, a pending `m_kx` word is withdrawn, and the TX frame is abandoned. Both FSMs return to HUNT/IDLE and `err_count` clears.

## Timing
- Reset values:
  - all `tvalid`/`tready` outputs 0 while `rst`=1;
  - after release `s_byte_tready`=1 and `s_y_tready`=1;
  - `m_kx_tdata` 0, `m_byte_tdata` 0, `frame_err` 0, `err_count` 0.
- Checksum byte accepted in cycle N -> `m_kx_tvalid`=1 in N+1; `frame_err` (bad frame) also in N+1.
- Throughput: at most one byte per cycle on each byte port; back-to-back frames need no gap.
- `s_y` handshake in cycle N -> SYNC on `m_byte_tdata` with `m_byte_tvalid`=1 in N+1.
- A frame of N_OUT+2 bytes takes N_OUT+2 cycles with `m_byte_tready` held at 1.
- `err_count` updates in the same cycle as `frame_err`. At 16'hFFFF the pulse still fires; the count holds.

## Test plan
Bench parameters: W_IN=16, R=2, W_Y=12, W_Y_OUT=16, SYNC=8'hA5, TIMEOUT=100.
- Good frame: bytes A5 34 12 26 -> `m_kx_tdata`=16'h1234 valid one cycle after 26. Hold `m_kx_tready`=0 for 5 cycles -> data stable and `s_byte_tready`=0.
- Bad checksum: A5 34 12 00 -> no `m_kx_tvalid`, one `frame_err` pulse, `err_count`=1. Then send the good frame -> 16'h1234 issued.
- Hunt and in-payload sync: 00 FF A5 A5 12 B7 -> first two bytes dropped; `m_kx_tdata`=16'h12A5.
- Timeout: A5 34, idle 101 cycles, then 12 26 -> abort pulse and `err_count`+1. The 12 and 26 bytes are dropped in HUNT and no word is issued. A byte arriving exactly on the timeout cycle is kept.
- TX extension: y0=12'hFFE, y1=12'h005.
  - SIGNED=1 -> A5 FE FF 05 00 04.
  - SIGNED=0 -> A5 FE 0F 05 00 F4.
  - Random `m_byte_tready` stalls -> identical sequence with data stable during stalls.
- Reset mid-frame: `rst` pulse after A5 34 and mid-TX DATA -> all valids 0 and `err_count`=0. A subsequent good frame and result transfer complete correctly.
